// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the shared LC-3 memory port arbiter:
// two requester ports, the memory side, and status.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;
    logic          gnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, gnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, gnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port
// between the CPU sequencer (port 0) and the debug loader (port 1).
module mem_port_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic clk,
    input  logic reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t        state;
    logic [3:0]    waitCnt;
    logic          lastGnt;
    logic          gntQ;
    logic          opWe;
    logic          memEn;
    logic          memWe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata;
    logic          cpuAck;
    logic          dbgAck;
    logic [DW-1:0] cpuRdata;
    logic [DW-1:0] dbgRdata;
    logic          busyQ;

    // Debug wins when it is alone or when the CPU had the last grant.
    logic anyReq;
    logic pickDbg;
    assign anyReq  = bus.cpu_req | bus.dbg_req;
    assign pickDbg = bus.dbg_req & (~bus.cpu_req | ~lastGnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            waitCnt  <= '0;
            lastGnt  <= 1'b1;
            gntQ     <= 1'b0;
            opWe     <= 1'b0;
            memEn    <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            cpuAck   <= 1'b0;
            dbgAck   <= 1'b0;
            cpuRdata <= '0;
            dbgRdata <= '0;
            busyQ    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (anyReq) begin
                        gntQ    <= pickDbg;
                        lastGnt <= pickDbg;
                        memEn   <= 1'b1;
                        busyQ   <= 1'b1;
                        state   <= ISSUE;
                        if (pickDbg) begin
                            opWe     <= bus.dbg_we;
                            memWe    <= bus.dbg_we;
                            memAddr  <= bus.dbg_addr;
                            memWdata <= bus.dbg_wdata;
                        end else begin
                            opWe     <= bus.cpu_we;
                            memWe    <= bus.cpu_we;
                            memAddr  <= bus.cpu_addr;
                            memWdata <= bus.cpu_wdata;
                        end
                    end
                end
                ISSUE: begin
                    memEn   <= 1'b0;
                    memWe   <= 1'b0;
                    waitCnt <= LAT;
                    state   <= WAIT;
                end
                WAIT: begin
                    // Count 1 marks the edge on which read data is valid.
                    if (waitCnt <= 4'd1) begin
                        waitCnt <= '0;
                        state   <= DONE;
                        cpuAck  <= ~gntQ;
                        dbgAck  <= gntQ;
                        if (!opWe) begin
                            if (gntQ) begin
                                dbgRdata <= bus.mem_rdata;
                            end else begin
                                cpuRdata <= bus.mem_rdata;
                            end
                        end
                    end else begin
                        waitCnt <= waitCnt - 4'd1;
                    end
                end
                DONE: begin
                    cpuAck <= 1'b0;
                    dbgAck <= 1'b0;
                    busyQ  <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = memEn;
    assign bus.mem_we    = memWe;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;
    assign bus.cpu_ack   = cpuAck;
    assign bus.dbg_ack   = dbgAck;
    assign bus.cpu_rdata = cpuRdata;
    assign bus.dbg_rdata = dbgRdata;
    assign bus.busy      = busyQ;
    assign bus.gnt       = gntQ;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single LC-3 memory port (MAR/MDR-style memory) between two requesters: port 0, the CPU load/store/fetch sequencer, and port 1, the debug/program-loader port.
- Round-robin arbitration. The winning request's command is latched, a one-cycle memory strobe is issued, the block waits a fixed memory latency, then returns a one-cycle ack plus read data to the winner.
- Sits between the datapath's memory interface and the memory array.

Parameters:
- MEM_LAT, 1: cycles from the memory strobe edge until mem_rdata is valid. Legal range 1..15.
- AW, 16: address width.
- DW, 16: data width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- cpu_req  in  1  port 0 request; held high until cpu_ack.
- cpu_we  in  1  port 0 write (1) / read (0).
- cpu_addr  in  AW  port 0 address.
- cpu_wdata  in  DW  port 0 write data.
- cpu_ack  out  1  port 0 completion pulse.
- cpu_rdata  out  DW  port 0 read data, registered.
- dbg_req  in  1  port 1 request.
- dbg_we  in  1  port 1 write/read.
- dbg_addr  in  AW  port 1 address.
- dbg_wdata  in  DW  port 1 write data.
- dbg_ack  out  1  port 1 completion pulse.
- dbg_rdata  out  DW  port 1 read data, registered.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable, valid only with mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high in every state except IDLE.
- gnt  out  1  current or last granted port (0 = CPU, 1 = debug).

Behaviour:
- Reset values:
  - state = IDLE.
  - mem_en, mem_we, cpu_ack, dbg_ack, busy = 0.
  - mem_addr, mem_wdata, cpu_rdata, dbg_rdata = 0.
  - wait counter = 0.
  - last_gnt = 1, so the CPU wins the first tie.
- Reset wins over every state. A reset mid-transaction aborts it with no ack and no rdata update; the requester must re-request.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Samples cpu_req and dbg_req at each edge.
  - Only one request high: grant that port.
  - Both high: grant the port that is not last_gnt.
  - On grant: latch the winner's we/addr/wdata into mem_we/mem_addr/mem_wdata registers, set gnt and last_gnt to the winner, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_en = 1 and mem_we = latched we.
  - Load counter with MEM_LAT, go to WAIT.
- WAIT:
  - mem_en = 0; mem_addr and mem_wdata are held.
  - Counter decrements each cycle.
  - On the edge where the counter reaches 0 (the MEM_LAT-th edge after ISSUE), capture mem_rdata into the winner's rdata register if the access is a read, then go to DONE.
  - Writes leave both rdata registers unchanged.
- DONE (exactly 1 cycle):
  - The winner's ack = 1; the other port's ack = 0.
  - Requests are ignored in this cycle. Go to IDLE.
- Latency: request sampled at edge 0 → ISSUE in cycle 1 → WAIT in cycles 2..MEM_LAT+1 → ack in cycle MEM_LAT+2. Minimum occupancy per access is MEM_LAT+3 cycles, including the IDLE sample cycle.
- Changes to addr/we/wdata after the grant edge are ignored; the latched values are used.
- A requester that drops req before ack still gets its access completed and acked. The ack pulse is not suppressed.
- A req still high in the IDLE cycle after ack is treated as a new request.
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1… Neither port waits more than one other transaction.
- Only one transaction is in flight at a time. No pipelining and no queueing.

Test Plan:
- Reset hold 3 cycles → all outputs 0, busy = 0. Release with no requests → mem_en never asserts.
- MEM_LAT=1. cpu_req=1, we=0, addr=0x3000; memory returns 0x1234 → mem_en=1, mem_addr=0x3000 in cycle 1; cpu_ack=1 in cycle 3; cpu_rdata=0x1234; dbg_rdata stays 0.
- Both requests raised together after reset, both held until their ack → CPU acked first (gnt=0), debug acked next (gnt=1). Continue holding both → 4 further grants alternate 0,1,0,1.
- MEM_LAT=3. dbg write, addr=0x0040, wdata=0xBEEF → exactly one mem_en/mem_we pulse with 0x0040/0xBEEF; dbg_ack in cycle 5; cpu_rdata and dbg_rdata unchanged.
- CPU read granted, then cpu_addr changed to 0x1111 during WAIT → mem_addr stays the original 0x3000; data is returned for 0x3000.
- Reset asserted during WAIT → next cycle state is IDLE; no ack pulse; rdata stays 0; busy=0. A new request completes normally.
